// File: rtl/clock_div_prog.sv
// -----------------------------------------------------------------------------
// clock_div_prog
//
// Run-time programmable clock divider and tick generator. A counter runs
// 0 .. N-1 (N = active divisor). The module produces:
//   * div_clock, a registered divided clock that is high for N>>1 cycles and
//     low for N-(N>>1) cycles of each period
//   * tick, a registered one-cycle strobe at the wrap edge, intended as a
//     clock enable for slow-rate logic
//
// Changing the divisor: a new divisor is held as pending and is only applied
// at a wrap edge. This keeps every period whole, so no period is cut short.
//
// Optional feature: define CLOCK_DIV_SYNC_EN to add the sync_in port and the
// re-phasing logic that goes with it.
//
// Ports
//   clock         in   1      system clock, rising edge
//   reset         in   1      synchronous, active-low reset
//   enable        in   1      1 = count; 0 = freeze counter and div_clock
//   div_load      in   1      strobe: capture div_value as the new divisor
//   div_value     in   WIDTH  requested divisor; 0 and 1 are clamped to 2
//   sync_in       in   1      (CLOCK_DIV_SYNC_EN only) restart the period now
//   div_clock     out  1      divided clock
//   tick          out  1      one-cycle pulse per period
//   load_pending  out  1      a divisor has been captured but not yet applied
// -----------------------------------------------------------------------------
module clock_div_prog #(
    parameter int WIDTH       = 17,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_value,
`ifdef CLOCK_DIV_SYNC_EN
    input  logic             sync_in,
`endif
    output logic             div_clock,
    output logic             tick,
    output logic             load_pending
);

    localparam logic [WIDTH-1:0] DEFAULT_DIV_W = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             load_pending_q, load_pending_d;
    logic             div_clock_q, div_clock_d;
    logic             tick_q, tick_d;

    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] apply_value;
    logic             apply_valid;
    logic             wrap;

    // Divisors below 2 cannot make a period with both a high and a low
    // phase, so they are raised to 2.
    assign load_value = (div_value[WIDTH-1:1] == '0) ? WIDTH'(2) : div_value;

    // The value to use when a divisor is applied. A load on the same edge
    // overrides an older pending value, so the last value written wins.
    assign apply_value = div_load ? load_value : pend_q;
    assign apply_valid = div_load | load_pending_q;

    assign wrap = enable && (cnt_q == div_q - WIDTH'(1));

    always_comb begin
        cnt_d          = cnt_q;
        div_d          = div_q;
        pend_d         = pend_q;
        load_pending_d = load_pending_q;
        div_clock_d    = div_clock_q;
        tick_d         = 1'b0;

        // The load is captured whether or not the counter is enabled.
        if (div_load) begin
            pend_d         = load_value;
            load_pending_d = 1'b1;
        end

        if (enable) begin
            if (wrap) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                if (apply_valid) begin
                    div_d          = apply_value;
                    load_pending_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
            // div_clock comes from the count it will have after this edge, so
            // that the registered output lines up with the registered count.
            div_clock_d = (cnt_d < (div_d >> 1));
        end

`ifdef CLOCK_DIV_SYNC_EN
        // sync_in restarts the period regardless of enable. It also applies
        // any waiting divisor at once, because the period restarts here.
        if (sync_in) begin
            cnt_d          = '0;
            tick_d         = 1'b0;
            div_clock_d    = 1'b0;
            load_pending_d = 1'b0;
            if (apply_valid) begin
                div_d = apply_value;
            end
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q          <= '0;
            div_q          <= DEFAULT_DIV_W;
            pend_q         <= '0;
            load_pending_q <= 1'b0;
            div_clock_q    <= 1'b0;
            tick_q         <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            div_q          <= div_d;
            pend_q         <= pend_d;
            load_pending_q <= load_pending_d;
            div_clock_q    <= div_clock_d;
            tick_q         <= tick_d;
        end
    end

    assign div_clock    = div_clock_q;
    assign tick         = tick_q;
    assign load_pending = load_pending_q;

endmodule

// File: tb/tb_clock_div_prog.sv
// -----------------------------------------------------------------------------
// tb_clock_div_prog
//
// Self-checking bench for clock_div_prog. The reference model keeps the
// divider as plain integers: the number of edges counted in the current
// period, the period length and an optional waiting divisor. The expected
// div_clock and tick values are worked out from those integers.
// Directed scenarios follow the documented cases. A randomized run then
// compares every edge against the model.
// -----------------------------------------------------------------------------
module tb_clock_div_prog;

    localparam int WIDTH = 17;
    localparam int DEF   = 4;
`ifdef CLOCK_DIV_SYNC_EN
    localparam bit SYNC_EN = 1'b1;
`else
    localparam bit SYNC_EN = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             enable = 1'b0;
    logic             div_load = 1'b0;
    logic [WIDTH-1:0] div_value = '0;
    logic             sync_in = 1'b0;
    logic             div_clock;
    logic             tick;
    logic             load_pending;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_n;        // active period length
    int m_pos;      // edges counted in the current period
    int m_pn;       // waiting divisor
    bit m_pv;       // waiting divisor valid
    bit exp_clk;
    bit exp_tick;
    bit exp_pend;

    clock_div_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .div_load     (div_load),
        .div_value    (div_value),
`ifdef CLOCK_DIV_SYNC_EN
        .sync_in      (sync_in),
`endif
        .div_clock    (div_clock),
        .tick         (tick),
        .load_pending (load_pending)
    );

    always #5 clock = ~clock;

    // Apply one set of inputs across one rising edge, then advance the model.
    // Outputs are valid 1 time unit after the edge, which is when the caller
    // compares them.
    task automatic drive_edge(input bit rst_n, input bit en, input bit ld,
                              input int val, input bit sy);
        int lv;
        bit applied;
        reset     = rst_n;
        enable    = en;
        div_load  = ld;
        div_value = WIDTH'(val);
        sync_in   = sy;
        @(posedge clock);
        #1;
        lv       = (val < 2) ? 2 : val;
        applied  = 1'b0;
        exp_tick = 1'b0;
        if (!rst_n) begin
            m_n = DEF; m_pos = 0; m_pv = 1'b0; m_pn = 0;
            exp_clk = 1'b0;
        end else if (SYNC_EN && sy) begin
            m_pos = 0;
            exp_clk = 1'b0;
            if (ld) m_n = lv;
            else if (m_pv) m_n = m_pn;
            m_pv = 1'b0;
            applied = 1'b1;
        end else begin
            if (en) begin
                m_pos = m_pos + 1;
                if (m_pos == m_n) begin
                    m_pos = 0;
                    exp_tick = 1'b1;
                    if (ld) begin
                        m_n = lv; m_pv = 1'b0; applied = 1'b1;
                    end else if (m_pv) begin
                        m_n = m_pn; m_pv = 1'b0;
                    end
                end
                exp_clk = (m_pos < m_n / 2);
            end
            if (ld && !applied) begin
                m_pn = lv; m_pv = 1'b1;
            end
        end
        exp_pend = m_pv;
    endtask

    task automatic test_reset();
        drive_edge(1'b0, 1'b1, 1'b0, 0, 1'b0);
        drive_edge(1'b0, 1'b1, 1'b1, 9, 1'b0);
        checks++;
        if ({div_clock, tick, load_pending} !== 3'b000) begin
            failures++;
            $display("FAIL reset_outputs: got clk/tick/pend=%b want 000",
                     {div_clock, tick, load_pending});
        end
    endtask

    task automatic test_basic();
        bit [7:0] seq_clk;
        bit [7:0] seq_tick;
        seq_clk  = 8'b1001_1001;   // edge 1 in the MSB
        seq_tick = 8'b0001_0001;
        for (int i = 0; i < 8; i++) begin
            drive_edge(1'b1, 1'b1, 1'b0, 0, 1'b0);
            checks++;
            if (div_clock !== seq_clk[7-i] || tick !== seq_tick[7-i]) begin
                failures++;
                $display("FAIL basic_n4 edge %0d: got clk=%b tick=%b want clk=%b tick=%b",
                         i + 1, div_clock, tick, seq_clk[7-i], seq_tick[7-i]);
            end
        end
    endtask

    task automatic test_load();
        int highs;
        int ticks;
        // Starts at a period boundary with N=4; load 5 at edge 2.
        for (int i = 1; i <= 4; i++) begin
            drive_edge(1'b1, 1'b1, (i == 2), 5, 1'b0);
            checks++;
            if (load_pending !== (i == 2 || i == 3) || tick !== (i == 4)) begin
                failures++;
                $display("FAIL load5 edge %0d: got pend=%b tick=%b want pend=%b tick=%b",
                         i, load_pending, tick, (i == 2 || i == 3), (i == 4));
            end
        end
        highs = 0;
        ticks = 0;
        for (int i = 1; i <= 5; i++) begin
            drive_edge(1'b1, 1'b1, 1'b0, 0, 1'b0);
            highs += int'(div_clock);
            ticks += int'(tick);
            checks++;
            if ({div_clock, tick, load_pending} !== {exp_clk, exp_tick, exp_pend}) begin
                failures++;
                $display("FAIL load5_period edge %0d: got %b want %b", i,
                         {div_clock, tick, load_pending}, {exp_clk, exp_tick, exp_pend});
            end
        end
        checks++;
        if (highs !== 2 || ticks !== 1 || tick !== 1'b1) begin
            failures++;
            $display("FAIL load5_shape: got highs=%0d ticks=%0d last_tick=%b want 2 1 1",
                     highs, ticks, tick);
        end
    endtask

    task automatic test_double_load();
        int ticks;
        // Starts at a period boundary with N=5: load 7 then 3, wrap at edge 5.
        for (int i = 1; i <= 5; i++) begin
            drive_edge(1'b1, 1'b1, (i <= 2), (i == 1) ? 7 : 3, 1'b0);
            checks++;
            if ({div_clock, tick, load_pending} !== {exp_clk, exp_tick, exp_pend}) begin
                failures++;
                $display("FAIL double_load edge %0d: got %b want %b", i,
                         {div_clock, tick, load_pending}, {exp_clk, exp_tick, exp_pend});
            end
        end
        checks++;
        if (tick !== 1'b1 || load_pending !== 1'b0) begin
            failures++;
            $display("FAIL double_load_wrap: got tick=%b pend=%b want 1 0", tick, load_pending);
        end
        ticks = 0;
        for (int i = 1; i <= 6; i++) begin
            drive_edge(1'b1, 1'b1, 1'b0, 0, 1'b0);
            ticks += int'(tick);
            checks++;
            if (tick !== (i % 3 == 0)) begin
                failures++;
                $display("FAIL double_load_n3 edge %0d: got tick=%b want %b", i, tick, (i % 3 == 0));
            end
        end
        checks++;
        if (ticks !== 2) begin
            failures++;
            $display("FAIL double_load_count: got %0d ticks want 2", ticks);
        end
    endtask

    task automatic test_enable_hold();
        bit held;
        drive_edge(1'b1, 1'b1, 1'b0, 0, 1'b0);
        held = div_clock;
        for (int i = 1; i <= 10; i++) begin
            drive_edge(1'b1, 1'b0, 1'b0, 0, 1'b0);
            checks++;
            if (div_clock !== held || tick !== 1'b0) begin
                failures++;
                $display("FAIL enable_hold cycle %0d: got clk=%b tick=%b want clk=%b tick=0",
                         i, div_clock, tick, held);
            end
        end
        for (int i = 1; i <= 6; i++) begin
            drive_edge(1'b1, 1'b1, 1'b0, 0, 1'b0);
            checks++;
            if ({div_clock, tick, load_pending} !== {exp_clk, exp_tick, exp_pend}) begin
                failures++;
                $display("FAIL enable_resume edge %0d: got %b want %b", i,
                         {div_clock, tick, load_pending}, {exp_clk, exp_tick, exp_pend});
            end
        end
    endtask

    task automatic test_clamp();
        bit prev;
        int ticks;
        for (int v = 0; v <= 1; v++) begin
            drive_edge(1'b1, 1'b1, 1'b1, v, 1'b0);
            for (int i = 0; i < 4; i++) drive_edge(1'b1, 1'b1, 1'b0, 0, 1'b0);
            ticks = 0;
            for (int i = 1; i <= 6; i++) begin
                prev = div_clock;
                drive_edge(1'b1, 1'b1, 1'b0, 0, 1'b0);
                ticks += int'(tick);
                checks++;
                if (div_clock === prev || {div_clock, tick} !== {exp_clk, exp_tick}) begin
                    failures++;
                    $display("FAIL clamp_%0d edge %0d: got clk=%b tick=%b want clk=%b tick=%b",
                             v, i, div_clock, tick, exp_clk, exp_tick);
                end
            end
            checks++;
            if (ticks !== 3) begin
                failures++;
                $display("FAIL clamp_%0d_count: got %0d ticks want 3", v, ticks);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive_edge(1'b1, 1'b1, 1'b1, 9, 1'b0);
        drive_edge(1'b1, 1'b1, 1'b0, 0, 1'b0);
        drive_edge(1'b0, 1'b1, 1'b0, 0, 1'b0);
        checks++;
        if ({div_clock, tick, load_pending} !== 3'b000) begin
            failures++;
            $display("FAIL reset_mid_outputs: got %b want 000", {div_clock, tick, load_pending});
        end
        for (int i = 1; i <= 8; i++) begin
            drive_edge(1'b1, 1'b1, 1'b0, 0, 1'b0);
            checks++;
            if (tick !== (i % DEF == 0) || load_pending !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_default edge %0d: got tick=%b pend=%b want tick=%b pend=0",
                         i, tick, load_pending, (i % DEF == 0));
            end
        end
    endtask

`ifdef CLOCK_DIV_SYNC_EN
    task automatic test_sync();
        drive_edge(1'b0, 1'b1, 1'b0, 0, 1'b0);
        drive_edge(1'b1, 1'b1, 1'b0, 0, 1'b0);
        drive_edge(1'b1, 1'b1, 1'b1, 6, 1'b0);   // count now 2, divisor 6 waiting
        drive_edge(1'b1, 1'b0, 1'b0, 0, 1'b1);   // sync with enable low
        checks++;
        if ({div_clock, tick, load_pending} !== 3'b000) begin
            failures++;
            $display("FAIL sync_pulse: got %b want 000", {div_clock, tick, load_pending});
        end
        for (int i = 1; i <= 6; i++) begin
            drive_edge(1'b1, 1'b1, 1'b0, 0, 1'b0);
            checks++;
            if (tick !== (i == 6) || div_clock !== (i < 3 || i == 6)) begin
                failures++;
                $display("FAIL sync_resume edge %0d: got clk=%b tick=%b want clk=%b tick=%b",
                         i, div_clock, tick, (i < 3 || i == 6), (i == 6));
            end
        end
    endtask
`endif

    task automatic test_random();
        bit en, ld, sy;
        int val;
        for (int i = 0; i < 400; i++) begin
            en  = ($urandom_range(0, 9) < 8);
            ld  = ($urandom_range(0, 9) == 0);
            sy  = SYNC_EN && ($urandom_range(0, 49) == 0);
            val = $urandom_range(0, 9);
            drive_edge(($urandom_range(0, 199) != 0), en, ld, val, sy);
            checks++;
            if ({div_clock, tick, load_pending} !== {exp_clk, exp_tick, exp_pend}) begin
                failures++;
                $display("FAIL random edge %0d: got clk/tick/pend=%b want %b", i,
                         {div_clock, tick, load_pending}, {exp_clk, exp_tick, exp_pend});
            end
        end
    endtask

    initial begin
        m_n = DEF; m_pos = 0; m_pn = 0; m_pv = 1'b0;
        exp_clk = 1'b0; exp_tick = 1'b0; exp_pend = 1'b0;
        test_reset();
        test_basic();
        test_load();
        test_double_load();
        test_enable_hold();
        test_clamp();
        test_reset_mid();
`ifdef CLOCK_DIV_SYNC_EN
        test_sync();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
